// File: rtl/id_pkg.sv
// id_pkg: shared opcode constants, ALU-op encodings, immediate formats and the
// per-opcode control bundle used by the decode stage.
package id_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_R   = 2'b10;
   localparam logic [1:0] ALU_I   = 2'b11;
   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
   typedef struct packed {
      logic       alusrc, memtoreg, regwrite, memread, memwrite;
      logic       branch, jal, jalr, auipc, lui;
      logic [1:0] aluop;
      logic       use_rs1, use_rs2, known;
      imm_fmt_e   fmt;
   } ctrl_t;
   function automatic ctrl_t decode(input logic [6:0] op);
      ctrl_t c;
      c = '0;
      c.known = 1'b1;
      case (op)
         OP_R:      begin c.regwrite = 1'b1; c.aluop = ALU_R; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
         OP_I:      begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_I; c.use_rs1 = 1'b1; c.fmt = IMM_I; end
         OP_LOAD:   begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; c.use_rs1 = 1'b1; c.fmt = IMM_I; end
         OP_STORE:  begin c.alusrc = 1'b1; c.memwrite = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = IMM_S; end
         OP_BRANCH: begin c.branch = 1'b1; c.aluop = ALU_BR; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = IMM_B; end
         OP_JAL:    begin c.regwrite = 1'b1; c.jal = 1'b1; c.fmt = IMM_J; end
         OP_JALR:   begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.jalr = 1'b1; c.use_rs1 = 1'b1; c.fmt = IMM_I; end
         OP_AUIPC:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.auipc = 1'b1; c.fmt = IMM_U; end
         OP_LUI:    begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.lui = 1'b1; c.fmt = IMM_U; end
         default:   c.known = 1'b0;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/id_if.sv
// id_if: IF/ID instruction slot, writeback port and ID/EX outputs of the decode stage.
interface id_if #(parameter int XLEN = 32);
   logic            if_valid_in, flush_in, wb_regwrite_in;
   logic [XLEN-1:0] if_pc_in, wb_data_in;
   logic [31:0]     if_instr_in;
   logic [4:0]      wb_rd_in;
   logic            stall_out, valid_out, illegal_out;
   logic [XLEN-1:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
   logic [4:0]      rd_out, rs1_out, rs2_out;
   logic [2:0]      funct3_out;
   logic [6:0]      funct7_out;
   logic            alusrc_out, memtoreg_out, regwrite_out, memread_out, memwrite_out;
   logic            branch_out, jal_out, jalr_out, auipc_out, lui_out;
   logic [1:0]      aluop_out;
   modport master (
      output if_valid_in, if_pc_in, if_instr_in, flush_in, wb_regwrite_in, wb_rd_in, wb_data_in,
      input  stall_out, valid_out, illegal_out, pc_out, rs1_data_out, rs2_data_out, imm_out,
             rd_out, rs1_out, rs2_out, funct3_out, funct7_out, alusrc_out, memtoreg_out,
             regwrite_out, memread_out, memwrite_out, branch_out, jal_out, jalr_out,
             auipc_out, lui_out, aluop_out
   );
   modport slave (
      input  if_valid_in, if_pc_in, if_instr_in, flush_in, wb_regwrite_in, wb_rd_in, wb_data_in,
      output stall_out, valid_out, illegal_out, pc_out, rs1_data_out, rs2_data_out, imm_out,
             rd_out, rs1_out, rs2_out, funct3_out, funct7_out, alusrc_out, memtoreg_out,
             regwrite_out, memread_out, memwrite_out, branch_out, jal_out, jalr_out,
             auipc_out, lui_out, aluop_out
   );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: NREG x XLEN register file, one synchronous write, two bypassed reads, x0 hard zero.
module id_regfile #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int REG_INIT = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   localparam int AW = $clog2(NREG);
   logic [XLEN-1:0] rf [NREG];
   logic wq;
   assign wq = we && wa != '0 && {1'b0, wa} < 6'(NREG);
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int k = 0; k < NREG; k++) rf[k] <= (REG_INIT != 0 && k != 0) ? XLEN'(k + 1) : '0;
      else if (wq)
         rf[wa[AW-1:0]] <= wd;
   // same-cycle writeback is forwarded so ID never sees a stale operand
   always_comb begin
      rd1 = ra1 == '0 || {1'b0, ra1} >= 6'(NREG) ? '0 : wq && wa == ra1 ? wd : rf[ra1[AW-1:0]];
      rd2 = ra2 == '0 || {1'b0, ra2} >= 6'(NREG) ? '0 : wq && wa == ra2 ? wd : rf[ra2[AW-1:0]];
   end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I/E instruction decode with register file, load-use stall detection
// and the ID/EX pipeline register.
module id_stage
   import id_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int REG_INIT = 0
) (
   input logic clk,
   input logic reset,
   id_if.slave bus
);
   logic [31:0]        ins;
   logic [4:0]         rd, rs1, rs2;
   logic [XLEN-1:0]    rs1_data, rs2_data;
   logic signed [31:0] imm32;
   ctrl_t              c;
   logic               bad_reg, illegal, load, on;
   assign ins = bus.if_instr_in;
   assign rd  = ins[11:7];
   assign rs1 = ins[19:15];
   assign rs2 = ins[24:20];
   assign c   = decode(ins[6:0]);
   id_regfile #(.XLEN(XLEN), .NREG(NREG), .REG_INIT(REG_INIT)) u_rf (
      .clk, .reset, .we(bus.wb_regwrite_in), .wa(bus.wb_rd_in), .wd(bus.wb_data_in),
      .ra1(rs1), .ra2(rs2), .rd1(rs1_data), .rd2(rs2_data)
   );
   always_comb begin
      imm32 = c.fmt == IMM_I ? {{20{ins[31]}}, ins[31:20]}
            : c.fmt == IMM_S ? {{20{ins[31]}}, ins[31:25], ins[11:7]}
            : c.fmt == IMM_B ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}
            : c.fmt == IMM_U ? {ins[31:12], 12'b0}
            : c.fmt == IMM_J ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}
            : '0;
      bad_reg = (c.regwrite && {1'b0, rd} >= 6'(NREG)) || (c.use_rs1 && {1'b0, rs1} >= 6'(NREG))
             || (c.use_rs2 && {1'b0, rs2} >= 6'(NREG));
      illegal = !c.known || bad_reg;
      // a load in EX whose result the IF/ID instruction needs; a flush makes it moot
      bus.stall_out = bus.if_valid_in && bus.valid_out && bus.memread_out && bus.rd_out != '0
                   && ((c.use_rs1 && rs1 == bus.rd_out) || (c.use_rs2 && rs2 == bus.rd_out))
                   && !bus.flush_in;
      load = bus.if_valid_in && !bus.flush_in && !bus.stall_out;
      on   = load && !illegal;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bus.valid_out    <= 1'b0;
         bus.illegal_out  <= 1'b0;
         bus.pc_out       <= '0;
         bus.rs1_data_out <= '0;
         bus.rs2_data_out <= '0;
         bus.imm_out      <= '0;
         bus.rd_out       <= '0;
         bus.rs1_out      <= '0;
         bus.rs2_out      <= '0;
         bus.funct3_out   <= '0;
         bus.funct7_out   <= '0;
         bus.alusrc_out   <= 1'b0;
         bus.memtoreg_out <= 1'b0;
         bus.regwrite_out <= 1'b0;
         bus.memread_out  <= 1'b0;
         bus.memwrite_out <= 1'b0;
         bus.branch_out   <= 1'b0;
         bus.jal_out      <= 1'b0;
         bus.jalr_out     <= 1'b0;
         bus.auipc_out    <= 1'b0;
         bus.lui_out      <= 1'b0;
         bus.aluop_out    <= '0;
      end else begin
         bus.valid_out    <= load;
         bus.illegal_out  <= load && illegal;
         bus.pc_out       <= load ? bus.if_pc_in : '0;
         bus.rs1_data_out <= load ? rs1_data : '0;
         bus.rs2_data_out <= load ? rs2_data : '0;
         bus.imm_out      <= load ? XLEN'(imm32) : '0;
         bus.rd_out       <= load ? rd : '0;
         bus.rs1_out      <= load ? rs1 : '0;
         bus.rs2_out      <= load ? rs2 : '0;
         bus.funct3_out   <= load ? ins[14:12] : '0;
         bus.funct7_out   <= load ? ins[31:25] : '0;
         bus.alusrc_out   <= on && c.alusrc;
         bus.memtoreg_out <= on && c.memtoreg;
         bus.regwrite_out <= on && c.regwrite;
         bus.memread_out  <= on && c.memread;
         bus.memwrite_out <= on && c.memwrite;
         bus.branch_out   <= on && c.branch;
         bus.jal_out      <= on && c.jal;
         bus.jalr_out     <= on && c.jalr;
         bus.auipc_out    <= on && c.auipc;
         bus.lui_out      <= on && c.lui;
         bus.aluop_out    <= on ? c.aluop : '0;
      end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed stimulus checked every cycle against a behavioural decode model,
// plus hand-computed literal expectations for both an RV32I and an RV32E instance.
module tb_id_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v = 1'b0, fl = 1'b0, wre = 1'b0;
   logic [31:0] pc = '0, ins = '0, wdat = '0;
   logic [4:0]  wrd = '0;
   int          checks = 0, errors = 0;

   id_if #(.XLEN(32)) a ();
   id_if #(.XLEN(32)) b ();
   id_stage #(.XLEN(32), .NREG(32), .REG_INIT(1)) dut   (.clk(clk), .reset(rst), .bus(a));
   id_stage #(.XLEN(32), .NREG(16), .REG_INIT(0)) dut16 (.clk(clk), .reset(rst), .bus(b));

   assign a.if_valid_in = v;   assign b.if_valid_in = v;
   assign a.if_pc_in = pc;     assign b.if_pc_in = pc;
   assign a.if_instr_in = ins; assign b.if_instr_in = ins;
   assign a.flush_in = fl;     assign b.flush_in = fl;
   assign a.wb_regwrite_in = wre; assign b.wb_regwrite_in = wre;
   assign a.wb_rd_in = wrd;    assign b.wb_rd_in = wrd;
   assign a.wb_data_in = wdat; assign b.wb_data_in = wdat;

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid, illegal;
      logic [31:0] pc, r1, r2, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] ctl;
   } exp_t;
   exp_t        e = '0;
   logic [31:0] mr [32];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
      end
   endtask

   // {known, alusrc,memtoreg,regwrite,memread,memwrite,branch,jal,jalr,auipc,lui,aluop[1:0]}
   function automatic logic [12:0] ctab(input logic [6:0] op);
      case (op)
         7'h33:   return 13'b1_0010_0000_0010;
         7'h13:   return 13'b1_1010_0000_0011;
         7'h03:   return 13'b1_1111_0000_0000;
         7'h23:   return 13'b1_1000_1000_0000;
         7'h63:   return 13'b1_0000_0100_0001;
         7'h6F:   return 13'b1_0010_0010_0000;
         7'h67:   return 13'b1_1010_0001_0000;
         7'h17:   return 13'b1_1010_0000_1000;
         7'h37:   return 13'b1_1010_0000_0100;
         default: return '0;
      endcase
   endfunction
   function automatic bit use1(input logic [6:0] op);
      return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
   endfunction
   function automatic bit use2(input logic [6:0] op);
      return op inside {7'h33, 7'h23, 7'h63};
   endfunction
   function automatic logic [31:0] mimm(input logic [31:0] i);
      case (i[6:0])
         7'h13, 7'h03, 7'h67: return 32'(i[30:20]) - (i[31] ? 32'd2048 : 32'd0);
         7'h23:        return 32'({i[30:25], i[11:7]}) - (i[31] ? 32'd2048 : 32'd0);
         7'h63:        return 32'(i[7]) * 32'd2048 + 32'(i[30:25]) * 32'd32 + 32'(i[11:8]) * 32'd2
                              - (i[31] ? 32'd4096 : 32'd0);
         7'h37, 7'h17: return 32'(i[31:12]) * 32'd4096;
         7'h6F:        return 32'(i[19:12]) * 32'd4096 + 32'(i[20]) * 32'd2048 + 32'(i[30:21]) * 32'd2
                              - (i[31] ? 32'h0010_0000 : 32'd0);
         default:      return '0;
      endcase
   endfunction
   function automatic logic [31:0] mrd(input logic [4:0] r);
      return r == 5'd0 ? 32'd0 : (wre && wrd != 5'd0 && wrd == r) ? wdat : mr[r];
   endfunction
   function automatic bit mstall();
      return v && e.valid && e.ctl[8] && e.rd != 5'd0 && !fl
          && ((use1(ins[6:0]) && ins[19:15] == e.rd) || (use2(ins[6:0]) && ins[24:20] == e.rd));
   endfunction
   function automatic exp_t mnext();
      exp_t        n = '0;
      logic [12:0] t = ctab(ins[6:0]);
      if (!v || fl || mstall()) return n;
      n.valid = 1'b1;
      n.illegal = !t[12];
      n.ctl = t[11:0];
      n.pc = pc;
      n.r1 = mrd(ins[19:15]);
      n.r2 = mrd(ins[24:20]);
      n.imm = mimm(ins);
      n.rd = ins[11:7];
      n.rs1 = ins[19:15];
      n.rs2 = ins[24:20];
      n.f3 = ins[14:12];
      n.f7 = ins[31:25];
      return n;
   endfunction

   always @(posedge clk or posedge rst)
      if (rst) begin
         e <= '0;
         for (int k = 0; k < 32; k++) mr[k] <= k == 0 ? 32'd0 : 32'(k + 1);
      end else begin
         e <= mnext();
         if (wre && wrd != 5'd0) mr[wrd] <= wdat;
      end

   always @(negedge clk) begin
      chk("valid", 32'(a.valid_out), 32'(e.valid));
      chk("illegal", 32'(a.illegal_out), 32'(e.illegal));
      chk("pc", a.pc_out, e.pc);
      chk("rs1_data", a.rs1_data_out, e.r1);
      chk("rs2_data", a.rs2_data_out, e.r2);
      chk("imm", a.imm_out, e.imm);
      chk("rd", 32'(a.rd_out), 32'(e.rd));
      chk("rs1", 32'(a.rs1_out), 32'(e.rs1));
      chk("rs2", 32'(a.rs2_out), 32'(e.rs2));
      chk("funct3", 32'(a.funct3_out), 32'(e.f3));
      chk("funct7", 32'(a.funct7_out), 32'(e.f7));
      chk("ctl", 32'({a.alusrc_out, a.memtoreg_out, a.regwrite_out, a.memread_out, a.memwrite_out,
                      a.branch_out, a.jal_out, a.jalr_out, a.auipc_out, a.lui_out, a.aluop_out}),
          32'(e.ctl));
      chk("stall", 32'(a.stall_out), 32'(mstall()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input logic [31:0] i);
      v = 1'b1;
      ins = i;
      pc = pc + 32'd4;
   endtask

   logic [31:0] tbl [8] = '{32'hFFF10093, 32'hFE512E23, 32'h010180E7, 32'h0000A283,
                            32'h00528333, 32'h80000217, 32'h00209863, 32'h0000007F};

   initial begin
      tick();
      tick();
      chk("rst_valid", 32'(a.valid_out), 32'd0);
      chk("rst_stall", 32'(a.stall_out), 32'd0);
      rst = 1'b0;
      // add x3,x1,x2 with the debug register image
      put(32'h002081B3); tick();
      chk("add_rs1", a.rs1_data_out, 32'd2);
      chk("add_rs2", a.rs2_data_out, 32'd3);
      chk("add_regwrite", 32'(a.regwrite_out), 32'd1);
      chk("add_aluop", 32'(a.aluop_out), 32'd2);
      chk("e_rs1_zero_init", b.rs1_data_out, 32'd0);
      // lw x5 then dependent add x6,x5,x5
      put(32'h0000A283); tick();
      put(32'h00528333); #1;
      chk("lu_stall", 32'(a.stall_out), 32'd1);
      tick();
      chk("lu_bubble", 32'(a.valid_out), 32'd0);
      chk("lu_stall_clear", 32'(a.stall_out), 32'd0);
      tick();
      chk("lu_issue", 32'(a.valid_out), 32'd1);
      chk("lu_rd", 32'(a.rd_out), 32'd6);
      chk("lu_rs1", a.rs1_data_out, 32'd6);
      // lw to x0 never stalls
      put(32'h0000A003); tick();
      put(32'h00000333); #1;
      chk("lw_x0_nostall", 32'(a.stall_out), 32'd0);
      tick();
      chk("lw_x0_issue", 32'(a.valid_out), 32'd1);
      // writeback bypass and x0
      wre = 1'b1; wrd = 5'd7; wdat = 32'hDEADBEEF;
      put(32'h00038433); tick();
      chk("wb_bypass", a.rs1_data_out, 32'hDEADBEEF);
      wre = 1'b0;
      tick();
      chk("wb_stored", a.rs1_data_out, 32'hDEADBEEF);
      wre = 1'b1; wrd = 5'd0; wdat = 32'hFFFFFFFF;
      put(32'h000004B3); tick();
      chk("x0_bypass", a.rs1_data_out, 32'd0);
      wre = 1'b0;
      put(32'h00000533); tick();
      chk("x0_read", a.rs1_data_out, 32'd0);
      // immediates
      put(32'hFE000CE3); tick();
      chk("beq_imm", a.imm_out, 32'hFFFFFFF8);
      chk("beq_branch", 32'(a.branch_out), 32'd1);
      chk("beq_aluop", 32'(a.aluop_out), 32'd1);
      put(32'h001000EF); tick();
      chk("jal_imm", a.imm_out, 32'h00000800);
      chk("jal_jal", 32'(a.jal_out), 32'd1);
      put(32'hABCDE0B7); tick();
      chk("lui_imm", a.imm_out, 32'hABCDE000);
      chk("lui_lui", 32'(a.lui_out), 32'd1);
      put(32'hFFF10093); tick();
      chk("addi_imm", a.imm_out, 32'hFFFFFFFF);
      put(32'hFE512E23); tick();
      chk("sw_imm", a.imm_out, 32'hFFFFFFFC);
      chk("sw_memwrite", 32'(a.memwrite_out), 32'd1);
      chk("sw_regwrite", 32'(a.regwrite_out), 32'd0);
      // flush beats a pending load-use stall
      put(32'h0000A283); tick();
      fl = 1'b1;
      put(32'h00528333); #1;
      chk("flush_nostall", 32'(a.stall_out), 32'd0);
      tick();
      chk("flush_bubble", 32'(a.valid_out), 32'd0);
      fl = 1'b0;
      tick();
      chk("post_flush_issue", 32'(a.valid_out), 32'd1);
      // register index beyond NREG and unknown opcode
      put(32'h002088B3); tick();
      chk("e_x17_illegal", 32'(b.illegal_out), 32'd1);
      chk("e_x17_regwrite", 32'(b.regwrite_out), 32'd0);
      chk("i_x17_legal", 32'(a.illegal_out), 32'd0);
      chk("i_x17_regwrite", 32'(a.regwrite_out), 32'd1);
      put(32'h0000007F); tick();
      chk("op7f_illegal", 32'(a.illegal_out), 32'd1);
      chk("op7f_illegal_e", 32'(b.illegal_out), 32'd1);
      chk("op7f_regwrite", 32'(a.regwrite_out), 32'd0);
      v = 1'b0; tick();
      chk("bubble_not_illegal", 32'(a.illegal_out), 32'd0);
      // reset during a stall with a writeback in flight
      put(32'h0000A283); tick();
      put(32'h00528333);
      wre = 1'b1; wrd = 5'd10; wdat = 32'h12345678; #1;
      chk("pre_rst_stall", 32'(a.stall_out), 32'd1);
      rst = 1'b1; #1;
      chk("async_rst_valid", 32'(a.valid_out), 32'd0);
      chk("async_rst_stall", 32'(a.stall_out), 32'd0);
      tick();
      rst = 1'b0; wre = 1'b0;
      put(32'h000505B3); tick();
      chk("rst_drop_write", a.rs1_data_out, 32'd11);
      chk("rst_first_valid", 32'(a.valid_out), 32'd1);
      // mixed stream with bubbles, writebacks and a flush
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 8; i++) begin
            put(tbl[i]);
            v = (i % 3) != 2;
            fl = r == 1 && i == 4;
            wre = i[0];
            wrd = 5'(i + 1 + r);
            wdat = 32'(32'h11111111 * (i + 1));
            tick();
         end
      v = 1'b0; fl = 1'b0; wre = 1'b0;
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 32, architectural register count (32 = RV32I, 16 = RV32E).
REQ-003 Parameter REG_INIT, default 0; 0 = registers reset to zero, 1 = register k resets to k+1 (debug image), x0 always 0.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 if_valid_in  in  1  IF/ID slot holds a real instruction.
REQ-007 if_pc_in  in  XLEN  PC of IF/ID instruction.
REQ-008 if_instr_in  in  32  instruction word.
REQ-009 flush_in  in  1  taken branch/jump resolved in EX; kill IF/ID instruction.
REQ-010 wb_regwrite_in  in  1  writeback enable.
REQ-011 wb_rd_in  in  5  writeback destination.
REQ-012 wb_data_in  in  XLEN  writeback data.
REQ-013 stall_out  out  1  combinational; IF must hold PC and IF/ID.
REQ-014 valid_out  out  1  ID/EX slot valid.
REQ-015 pc_out, rs1_data_out, rs2_data_out, imm_out  out  XLEN each  registered operands.
REQ-016 rd_out, rs1_out, rs2_out  out  5 each; funct3_out  out  3; funct7_out  out  7.
REQ-017 alusrc_out, memtoreg_out, regwrite_out, memread_out, memwrite_out, branch_out, jal_out, jalr_out, auipc_out, lui_out  out  1 each; aluop_out  out  2.
REQ-018 illegal_out  out  1  registered: valid instruction with unknown opcode or register index >= NREG.

Function
REQ-019 All outputs except stall_out SHALL be registered, updating one clk after the instruction is presented (latency 1).
REQ-020 Control per opcode: R: regwrite, aluop=10; I-ALU: alusrc, regwrite, aluop=11; LOAD: alusrc, memtoreg, regwrite, memread; STORE: alusrc, memwrite; BRANCH: branch, aluop=01; JAL: regwrite, jal; JALR: alusrc, regwrite, jalr; AUIPC: alusrc, regwrite, auipc; LUI: alusrc, regwrite, lui; other: all zero, illegal.
REQ-021 Immediate sign-extended to XLEN: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; R/other = 0.
REQ-022 Register file: NREG x XLEN, two combinational reads, one synchronous write when wb_regwrite_in, wb_rd_in != 0, wb_rd_in < NREG.
REQ-023 Read of x0 SHALL return 0 regardless of writes.
REQ-024 Write-through bypass: read index equal to wb_rd_in with a qualifying write in the same cycle SHALL return wb_data_in.
REQ-025 rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR; rs2 used by R, STORE, BRANCH.
REQ-026 Load-use hazard: stall_out = if_valid_in & valid_out & memread_out & rd_out != 0 & (rd_out matches a used rs1/rs2) & !flush_in.
REQ-027 On stall: ID/EX loads a bubble (valid_out=0, all control outputs 0); IF/ID instruction re-presented next cycle is decoded normally.
REQ-028 On flush_in: ID/EX loads a bubble; flush_in takes priority over stall; stall_out=0.
REQ-029 if_valid_in=0 SHALL load a bubble; bubbles SHALL never assert illegal_out.
REQ-030 Data fields (pc, operands, imm, indices, funct) of a bubble are don't-care but SHALL be deterministic (zero).

Reset
REQ-031 Reset asserted: all registered outputs 0 immediately (asynchronous), stall_out 0, register file loaded per REG_INIT.
REQ-032 Reset mid-stall or mid-write: write discarded, bubble state; first valid instruction after deassertion decoded normally.

Structure
REQ-033 Shared package id_pkg: opcode constants, aluop encodings, immediate-format enum, control-bundle struct.
REQ-034 Sub-module id_regfile (NREG, XLEN, REG_INIT): storage, write port, bypassed reads; decode and ID/EX register stay in id_stage.

Verification
REQ-035 Reset with REG_INIT=1, then add x3,x1,x2 (0x002081B3) valid -> rs1_data_out=2, rs2_data_out=3, regwrite_out=1, aluop_out=10.
REQ-036 lw x5,0(x1) then add x6,x5,x5 back-to-back -> stall_out=1 one cycle, one bubble, add issued next cycle; lw to x0 -> no stall.
REQ-037 wb write x7=0xDEADBEEF while decoding add x8,x7,x0 -> rs1_data_out=0xDEADBEEF same cycle; write to x0 -> reads 0.
REQ-038 beq with imm -8 (0xFE000CE3) -> imm_out=0xFFFFFFF8; jal x1,+2048 -> imm_out=0x00000800; lui x1,0xABCDE -> imm_out=0xABCDE000.
REQ-039 flush_in with load-use hazard present -> valid_out=0 next cycle, stall_out=0.
REQ-040 NREG=16, add x17,x1,x2 -> illegal_out=1, regwrite_out=0; opcode 0x7F -> illegal_out=1.
